// File: rtl/nac_axi_slave_adapter.sv
// AXI4 slave adapter: handles one burst at a time and turns it into single-port word-memory accesses.
// Defining NAC_AXI_SLV_ERR_EN adds SLVERR checks on burst type, size, address range and wlast.
module nac_axi_slave_adapter #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 40,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MEM_WORDS_LOG2   = 12
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [C_MEM_WORDS_LOG2-1:0]     mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = C_MEM_WORDS_LOG2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_WRESP  = 3'd2,
        S_RISSUE = 3'd3,
        S_RWAIT  = 3'd4,
        S_RDATA  = 3'd5
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic                            running;
    logic [IDX_W-1:0]                idx;
    logic [7:0]                      cnt;
    logic [7:0]                      len;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                            last_beat;
    logic                            aw_hs;
    logic                            ar_hs;
    logic                            w_hs;
    logic                            r_hs;
    logic                            wr_block;
    logic                            rd_block;
    logic                            unused_inputs;

    assign last_beat   = (cnt == len);
    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    assign s_axi_rdata = rdata_q;

`ifdef NAC_AXI_SLV_ERR_EN
    logic err;
    logic wlast_bad;

    // Flags a burst the memory cannot serve as a plain full-width INCR inside its range.
    function automatic logic ax_err(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr,
                                    input logic [7:0] blen,
                                    input logic [2:0] size,
                                    input logic [1:0] burst);
        logic [IDX_W+8:0] last_idx;
        last_idx = (IDX_W+9)'(addr[ADDR_LSB +: IDX_W]) + (IDX_W+9)'(blen);
        return (burst != 2'b01) || (size != 3'(ADDR_LSB)) ||
               ((addr >> (ADDR_LSB + IDX_W)) != '0) ||
               (last_idx[IDX_W+8:IDX_W] != '0);
    endfunction

    assign wlast_bad   = (s_axi_wlast != last_beat);
    assign wr_block    = err || wlast_bad;
    assign rd_block    = err;
    assign s_axi_bresp = (s_axi_bvalid && err) ? 2'b10 : 2'b00;
    assign s_axi_rresp = (s_axi_rvalid && err) ? 2'b10 : 2'b00;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            err <= 1'b0;
        end else if (aw_hs) begin
            err <= ax_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
        end else if (ar_hs) begin
            err <= ax_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
        end else if (w_hs && wlast_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign wr_block    = 1'b0;
    assign rd_block    = 1'b0;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_awburst,
                             s_axi_arsize, s_axi_arburst, s_axi_wlast};
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the handshake/memory strobes, all decoded from the current state.
    always_comb begin
        state_next    = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = idx;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        case (state)
            S_IDLE: begin
                // running keeps the slave quiet until the first edge after reset release
                if (running) begin
                    s_axi_awready = 1'b1;
                    s_axi_arready = !s_axi_awvalid;
                    if (s_axi_awvalid) begin
                        state_next = S_WDATA;
                    end else if (s_axi_arvalid) begin
                        state_next = S_RISSUE;
                    end
                end
            end
            S_WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_en    = !wr_block;
                    mem_we    = !wr_block;
                    mem_wdata = s_axi_wdata;
                    mem_wstrb = s_axi_wstrb;
                    if (last_beat) begin
                        state_next = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_next = S_IDLE;
                end
            end
            S_RISSUE: begin
                mem_en     = !rd_block;
                state_next = S_RWAIT;
            end
            S_RWAIT: begin
                state_next = S_RDATA;
            end
            S_RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                if (s_axi_rready) begin
                    state_next = last_beat ? S_IDLE : S_RISSUE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping and the read data holding register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            running <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            len     <= '0;
            rdata_q <= '0;
        end else begin
            running <= 1'b1;
            if (aw_hs) begin
                idx <= s_axi_awaddr[ADDR_LSB +: IDX_W];
                len <= s_axi_awlen;
                cnt <= '0;
            end else if (ar_hs) begin
                idx <= s_axi_araddr[ADDR_LSB +: IDX_W];
                len <= s_axi_arlen;
                cnt <= '0;
            end else if (w_hs || (r_hs && !last_beat)) begin
                idx <= idx + 1'b1;
                cnt <= cnt + 8'd1;
            end
            if (state == S_RWAIT) begin
                rdata_q <= rd_block ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_nac_axi_slave_adapter.sv
// Directed scoreboard bench for nac_axi_slave_adapter with a behavioural word memory.
// Expectations follow NAC_AXI_SLV_ERR_EN when the bench is built with it defined.
module tb_nac_axi_slave_adapter;

    localparam int unsigned AW    = 40;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 12;
    localparam int unsigned DEPTH = 1 << MW;
`ifdef NAC_AXI_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic [7:0]      awlen = '0;
    logic [2:0]      awsize = 3'd2;
    logic [1:0]      awburst = 2'b01;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic [7:0]      arlen = '0;
    logic [2:0]      arsize = 3'd2;
    logic [1:0]      arburst = 2'b01;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready = 1'b0;
    logic            mem_en;
    logic            mem_we;
    logic [MW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic [DW-1:0]   mem_rdata = '0;

    int      checks = 0;
    int      errors = 0;
    int      rd_en_cnt = 0;
    longint  cycle = 0;
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [MW-1:0] exp_wr_idx [$];
    logic [DW-1:0] exp_wr_data [$];
    logic [DW-1:0] exp_rd [$];
    longint        wr_cyc [$];

    nac_axi_slave_adapter #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_MEM_WORDS_LOG2  (MW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi_awaddr (awaddr),
        .s_axi_awlen  (awlen),
        .s_axi_awsize (awsize),
        .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wlast  (wlast),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arlen  (arlen),
        .s_axi_arsize (arsize),
        .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rlast  (rlast),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous memory: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory-side monitor: every write is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("mem_en_in_reset", 64'(mem_en), 64'd0);
        end else if (mem_en && mem_we) begin
            logic pend;
            pend = (exp_wr_idx.size() != 0);
            check("write_expected", 64'(pend), 64'd1);
            if (pend) begin
                check("write_idx", 64'(mem_addr), 64'(exp_wr_idx.pop_front()));
                check("write_data", 64'(mem_wdata), 64'(exp_wr_data.pop_front()));
            end
            wr_cyc.push_back(cycle);
        end else if (mem_en) begin
            rd_en_cnt++;
        end
    end

    task automatic wait_ready(input int sel, input string tag);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            case (sel)
                0:       ok = awready;
                1:       ok = arready;
                2:       ok = wready;
                3:       ok = bvalid;
                default: ok = rvalid;
            endcase
        end
        check({tag, "_wait"}, 64'(ok), 64'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [DW-1:0] base, input logic [1:0] exp_resp, input bit ar_pend);
        logic [MW-1:0] ix;
        awaddr = addr; awlen = 8'(len); awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        wait_ready(0, "aw");
        if (ar_pend) check("arready_while_awvalid", 64'(arready), 64'd0);
        wr_cyc.delete();
        for (int i = 0; i <= len; i++) begin
            ix = addr[2 +: MW] + MW'(i);
            if (exp_resp == 2'b00) begin
                exp_wr_idx.push_back(ix);
                exp_wr_data.push_back(base + DW'(i));
                ref_mem[ix] = base + DW'(i);
            end
        end
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = base + DW'(i); wstrb = '1; wlast = (i == len); wvalid = 1'b1;
            wait_ready(2, "w");
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (exp_resp == 2'b00) begin
            check("write_beats", 64'(wr_cyc.size()), 64'(len + 1));
            if (wr_cyc.size() != 0) check("write_back_to_back", 64'(wr_cyc[$] - wr_cyc[0]), 64'(len));
        end
        bready = 1'b1;
        wait_ready(3, "b");
        check("bresp", 64'(bresp), 64'(exp_resp));
        if (ar_pend) check("arready_during_b", 64'(arready), 64'd0);
        @(posedge clk); #1 bready = 1'b0;
        check("write_queue_drained", 64'(exp_wr_idx.size()), 64'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                           input int stall_beat, input bit exp_err);
        logic [DW-1:0] held;
        logic [DW-1:0] exp;
        int            en0;
        for (int i = 0; i <= len; i++) begin
            exp_rd.push_back(exp_err ? '0 : ref_mem[addr[2 +: MW] + MW'(i)]);
        end
        en0 = rd_en_cnt;
        araddr = addr; arlen = 8'(len); arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        wait_ready(1, "ar");
        @(posedge clk); #1 arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            rready = (i != stall_beat);
            wait_ready(4, "r");
            if (i == stall_beat) begin
                held = rdata;
                repeat (5) begin
                    @(negedge clk);
                    check("rdata_stable", 64'(rdata), 64'(held));
                    check("rvalid_held", 64'(rvalid), 64'd1);
                end
                @(posedge clk); #1 rready = 1'b1;
                @(negedge clk);
            end
            exp = exp_rd.pop_front();
            check("rdata", 64'(rdata), 64'(exp));
            check("rresp", 64'(rresp), exp_err ? 64'd2 : 64'd0);
            check("rlast", 64'(rlast), 64'(i == len));
            @(posedge clk); #1;
        end
        rready = 1'b0;
        check("read_mem_en_count", 64'(rd_en_cnt - en0), exp_err ? 64'd0 : 64'(len + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        // Reset state and first-edge behaviour after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_we}), 64'd0);
        check("reset_resp", 64'({bresp, rresp}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("awready_before_edge", 64'(awready), 64'd0);
        @(negedge clk);
        check("awready_first_edge", 64'(awready), 64'd1);
        @(posedge clk); #1;

        // Four-beat write at 0x10, then read back with a stall on beat 1
        do_write(40'h10, 3, 2'b01, 32'hA0, 2'b00, 1'b0);
        do_read(40'h10, 3, 2'b01, 1, 1'b0);

        // Simultaneous AW and AR: write first, read sees the new data
        arvalid = 1'b1; araddr = 40'h40; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2;
        do_write(40'h40, 0, 2'b01, 32'h55, 2'b00, 1'b1);
        do_read(40'h40, 0, 2'b01, -1, 1'b0);

        // Reset while beat 2 of an 8-beat write is pending
        awaddr = 40'h100; awlen = 8'd7; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
        wait_ready(0, "aw_rst");
        for (int i = 0; i < 2; i++) begin
            exp_wr_idx.push_back(MW'(12'h40 + i));
            exp_wr_data.push_back(32'hC0 + DW'(i));
            ref_mem[12'h40 + i] = 32'hC0 + DW'(i);
        end
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'hC0 + DW'(i); wvalid = 1'b1; wlast = 1'b0;
            wait_ready(2, "w_rst");
            @(posedge clk); #1;
        end
        wdata = 32'hC2; wvalid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({awready, arready, wready, bvalid, rvalid, rlast, mem_en, mem_we}), 64'd0);
        check("async_reset_rdata", 64'(rdata), 64'd0);
        wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("awready_after_midburst_reset", 64'(awready), 64'd1);
        check("aborted_beats_written", 64'(exp_wr_idx.size()), 64'd0);
        @(posedge clk); #1;
        do_write(40'h200, 1, 2'b01, 32'hD0, 2'b00, 1'b0);
        do_read(40'h100, 3, 2'b01, -1, 1'b0);
        do_read(40'h200, 1, 2'b01, -1, 1'b0);

        // WRAP read: SLVERR with error checking, plain data otherwise
        do_read(40'h10, 1, 2'b10, -1, ERR_EN);

        // Write at the top index wraps to index 0 (out of range when checked)
        do_write(40'h3FFC, 1, 2'b01, 32'hB0, ERR_EN ? 2'b10 : 2'b00, 1'b0);
        do_read(40'h0, 0, 2'b01, -1, 1'b0);
        do_read(40'h3FFC, 0, 2'b01, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nac_axi_slave_adapter.md
NAC_AXI_SLAVE_ADAPTER -- requirements
Module: nac_axi_slave_adapter

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 40, the AXI address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32 (legal values 32/64/128), the AXI and memory data width.
REQ-003 SHALL have parameter C_MEM_WORDS_LOG2, default 12, log2 of the backing memory depth in words.
REQ-004 SHALL have one clock and one reset:
- S_AXI_ACLK  in  1  sole clock, rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have AXI4 slave ports, widths per AXI4:
- AW: s_axi_awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid in; s_axi_awready out.
- W: s_axi_wdata/wstrb/wlast/wvalid in; s_axi_wready out.
- B: s_axi_bresp[1:0]/bvalid out; s_axi_bready in.
- AR: s_axi_araddr/arlen/arsize/arburst/arvalid in; s_axi_arready out.
- R: s_axi_rdata/rresp[1:0]/rlast/rvalid out; s_axi_rready in.
REQ-006 SHALL have memory ports:
- mem_en  out  1  access strobe.
- mem_we  out  1  write qualifier.
- mem_addr  out  C_MEM_WORDS_LOG2  word index.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  DATA_WIDTH/8  byte enables.
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_en with mem_we=0.

Function
REQ-007 SHALL run an FSM with states IDLE, WDATA, WRESP, RISSUE, RWAIT, RDATA; one transaction outstanding at a time.
REQ-008 In IDLE: awready=1; arready=!awvalid (write wins when AW and AR are valid in the same cycle); all other AXI valids/readies 0.
REQ-009 On AW handshake SHALL latch word index = awaddr>>log2(DATA_WIDTH/8) truncated to C_MEM_WORDS_LOG2 bits, plus awlen, clear the beat counter, and go to WDATA.
REQ-010 In WDATA: wready=1; each W handshake SHALL drive mem_en=mem_we=1 combinationally with mem_wdata=wdata, mem_wstrb=wstrb, mem_addr=current index; index and counter increment on each beat; one beat per cycle.
REQ-011 Burst end SHALL be determined by the counter reaching awlen; the beat after that handshake goes to WRESP with bvalid=1, held until bready; then IDLE.
REQ-012 On AR handshake SHALL latch index and arlen, then RISSUE: mem_en=1, mem_we=0, for one cycle -> RWAIT -> capture mem_rdata into rdata, rvalid=1 -> RDATA.
REQ-013 In RDATA: rvalid/rdata/rresp/rlast SHALL hold stable until rready; on handshake, the last beat (counter==arlen, rlast=1) goes to IDLE, otherwise increment index and return to RISSUE. Peak rate is one beat per 3 cycles.
REQ-014 Index SHALL wrap modulo 2^C_MEM_WORDS_LOG2; burst type is treated as INCR and awsize/arsize as full width unless errors are enabled.
REQ-015 bresp and rresp SHALL be OKAY (2'b00) unless REQ-019 applies.

Reset
REQ-016 On ARESETN low, SHALL immediately force state=IDLE and all of the following to 0: awready, arready, wready, bvalid, bresp, rvalid, rresp, rlast, rdata, mem_en, mem_we, counter, index.
REQ-017 Reset mid-burst SHALL abandon the burst with no further mem_en; after release, awready=1 on the first clock edge.
REQ-018 mem_en/mem_we SHALL never assert while ARESETN is low.

Configuration
REQ-019 With NAC_AXI_SLV_ERR_EN defined:
- SLVERR (2'b10) for any burst with burst!=INCR, size!=log2(DATA_WIDTH/8), start address bits above the memory range nonzero, or start index+len beyond the depth.
- On a write, wlast mismatching the counter's last beat SHALL also yield SLVERR.
- Erroneous write: all beats are still accepted, mem_en is suppressed, bresp=SLVERR.
- Erroneous read: no mem_en, rdata=0, rresp=SLVERR on every beat, rlast on the final beat.
REQ-020 Without NAC_AXI_SLV_ERR_EN: no checks, responses always OKAY, and no error logic is instantiated.

Verification
REQ-021 AW addr=0x10, len=3, then 4 beats 0xA0..0xA3 with wready continuous -> mem writes at indexes 4..7 on consecutive cycles; bresp=OKAY.
REQ-022 AR addr=0x10, len=3 with rready stalled 5 cycles on beat 1 -> rdata A0..A3 in order; rdata is stable during the stall; rlast only on the 4th beat.
REQ-023 AW and AR valid in the same cycle -> write completes with B before arready asserts; read then returns the written data.
REQ-024 ARESETN low during beat 2 of an 8-beat write -> all outputs reach 0 without a clock; no further mem_en; next transaction is correct.
REQ-025 NAC_AXI_SLV_ERR_EN defined, AR with arburst=WRAP, len=1 -> 2 beats with rresp=2'b10, rdata=0, no mem_en; undefined -> rresp=OKAY with memory data.
REQ-026 Write at index 2^C_MEM_WORDS_LOG2-1 with len=1, macro undefined -> second beat wraps to index 0.
